// File: rtl/weighted_quantum_rr_arbiter.sv
// Round-robin arbiter with a per-requester time quantum and a LOCK that defers expiry.
// The grant moves one-hot to one-hot between owners with no idle cycle in between.
module weighted_quantum_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         REQ,
    input  logic [N*CNT_W-1:0]   QUANTUM,
    input  logic                 LOCK,
    output logic [N-1:0]         GNT,
    output logic [$clog2(N)-1:0] GNT_ID,
    output logic                 GNT_VLD,
    output logic                 EXPIRED
);

    localparam int unsigned ID_W  = $clog2(N);
    localparam int unsigned IDX_W = ID_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [N-1:0]     GNT_ONE = N'(1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e           r_state, w_state_d;
    logic [ID_W-1:0]  r_last, w_last_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [CNT_W-1:0] r_q, w_q_d;
    logic [N-1:0]     r_gnt, w_gnt_d;

    logic             w_any_req;
    logic             w_found;
    logic [IDX_W-1:0] w_cand;
    logic [ID_W-1:0]  w_win;
    logic [CNT_W-1:0] w_field;
    logic [CNT_W-1:0] w_q_new;
    logic             w_quantum_up;
    logic             w_end;

    assign w_any_req = |REQ;

    // Search starts just after the last owner; the owner itself is the final candidate.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= int'(N); k++) begin
            w_cand = {1'b0, r_last} + IDX_W'(k);
            if (w_cand >= IDX_W'(N)) begin
                w_cand = w_cand - IDX_W'(N);
            end
            if (!w_found && REQ[w_cand[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[ID_W-1:0];
            end
        end
    end

    assign w_field      = QUANTUM[w_win*CNT_W +: CNT_W];
    assign w_q_new      = (w_field == '0) ? CNT_ONE : w_field;
    assign w_quantum_up = (r_cnt >= r_q) && !LOCK;
    assign w_end        = !REQ[r_last] || w_quantum_up;

    always_comb begin
        w_state_d = r_state;
        w_last_d  = r_last;
        w_cnt_d   = r_cnt;
        w_q_d     = r_q;
        w_gnt_d   = r_gnt;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_d = StGrant;
                    w_last_d  = w_win;
                    w_cnt_d   = CNT_ONE;
                    w_q_d     = w_q_new;
                    w_gnt_d   = GNT_ONE << w_win;
                end
            end
            StGrant: begin
                if (!w_end) begin
                    // Only LOCK can hold the count past the quantum, so saturate.
                    if (r_cnt != '1) begin
                        w_cnt_d = r_cnt + CNT_ONE;
                    end
                end else if (w_any_req) begin
                    w_last_d = w_win;
                    w_cnt_d  = CNT_ONE;
                    w_q_d    = w_q_new;
                    w_gnt_d  = GNT_ONE << w_win;
                end else begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                    w_gnt_d   = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_last  <= ID_W'(N - 1);
            r_cnt   <= '0;
            r_q     <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_last  <= w_last_d;
            r_cnt   <= w_cnt_d;
            r_q     <= w_q_d;
            r_gnt   <= w_gnt_d;
        end
    end

    assign GNT     = r_gnt;
    assign GNT_VLD = (r_state == StGrant);
    assign GNT_ID  = GNT_VLD ? r_last : '0;
    assign EXPIRED = (r_state == StGrant) && REQ[r_last] && w_quantum_up;

endmodule

// File: tb/tb_weighted_quantum_rr_arbiter.sv
// Directed scoreboard bench: each driven cycle pushes the expected grant and expiry,
// and a monitor pops and compares them once the outputs have settled.
module tb_weighted_quantum_rr_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*CNT_W-1:0] quantum;
    logic             lock;
    logic [N-1:0]     gnt;
    logic [1:0]       gnt_id;
    logic             gnt_vld;
    logic             expired;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic       exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t sb_e;
    int n_checks = 0;
    int n_fails  = 0;

    weighted_quantum_rr_arbiter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .REQ     (req),
        .QUANTUM (quantum),
        .LOCK    (lock),
        .GNT     (gnt),
        .GNT_ID  (gnt_id),
        .GNT_VLD (gnt_vld),
        .EXPIRED (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Drive one cycle's inputs and record what the outputs must show during that cycle.
    task automatic step(input string tag, input logic rst_n, input logic [3:0] r,
                        input logic [15:0] q, input logic lk,
                        input logic [3:0] exp_gnt, input logic exp_exp);
        sb_entry_t e;
        @(negedge clk);
        reset_n = rst_n;
        req     = r;
        quantum = q;
        lock    = lk;
        e.tag   = tag;
        e.gnt   = exp_gnt;
        e.exp   = exp_exp;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        #2;
        while (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check_eq({sb_e.tag, "_gnt"}, 32'(gnt), 32'(sb_e.gnt));
            check_eq({sb_e.tag, "_exp"}, 32'(expired), 32'(sb_e.exp));
            check_eq({sb_e.tag, "_vld"}, 32'(gnt_vld), 32'(|sb_e.gnt));
            check_eq({sb_e.tag, "_id"}, 32'(gnt_id), 32'(onehot_idx(sb_e.gnt)));
        end
    end

    initial begin
        reset_n = 1'b0;
        req     = 4'h0;
        quantum = 16'h4321;
        lock    = 1'b0;
        @(posedge clk);

        // Reset held with all requesting, then rotation through quanta 1,2,3,4.
        for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 4'hF, 16'h4321, 1'b0, 4'h0, 1'b0);
        step("rst_rel", 1'b1, 4'hF, 16'h4321, 1'b0, 4'h0, 1'b0);
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 4; i++) begin
                for (int c = 1; c <= i + 1; c++) begin
                    step("rot", 1'b1, 4'hF, 16'h4321, 1'b0, 4'(1 << i), c == i + 1);
                end
            end
        end
        step("rot_drop", 1'b1, 4'h0, 16'h4321, 1'b0, 4'b0001, 1'b0);
        step("rot_idle", 1'b1, 4'h0, 16'h4321, 1'b0, 4'h0, 1'b0);

        // Early release: one extra granted cycle after REQ falls, never expired.
        step("early_req", 1'b1, 4'b0001, 16'h0008, 1'b0, 4'h0, 1'b0);
        step("early_g1", 1'b1, 4'b0001, 16'h0008, 1'b0, 4'b0001, 1'b0);
        step("early_g2", 1'b1, 4'b0001, 16'h0008, 1'b0, 4'b0001, 1'b0);
        step("early_g3", 1'b1, 4'b0000, 16'h0008, 1'b0, 4'b0001, 1'b0);
        step("early_idle", 1'b1, 4'b0000, 16'h0008, 1'b0, 4'h0, 1'b0);

        // Sole requester re-granted continuously, expiring every 3rd cycle.
        step("sole_req", 1'b1, 4'b0100, 16'h0300, 1'b0, 4'h0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            step("sole", 1'b1, 4'b0100, 16'h0300, 1'b0, 4'b0100, (c % 3) == 0);
        end
        step("sole_drop", 1'b1, 4'b0000, 16'h0300, 1'b0, 4'b0100, 1'b0);
        step("sole_idle", 1'b1, 4'b0000, 16'h0300, 1'b0, 4'h0, 1'b0);

        // LOCK defers expiry of q0=2; releasing it at cnt=6 expires that cycle.
        step("lock_req", 1'b1, 4'b0011, 16'h0002, 1'b1, 4'h0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            step("lock_hold", 1'b1, 4'b0011, 16'h0002, 1'b1, 4'b0001, 1'b0);
        end
        step("lock_rel", 1'b1, 4'b0011, 16'h0002, 1'b0, 4'b0001, 1'b1);
        // Owner 1 has quantum field 0, treated as 1: expires on its first cycle.
        step("lock_next", 1'b1, 4'b0010, 16'h0050, 1'b0, 4'b0010, 1'b1);

        // Reset while owner 1 is mid-slice, then priority restarts at requester 0.
        step("mid_c1", 1'b1, 4'b0010, 16'h0050, 1'b0, 4'b0010, 1'b0);
        step("mid_rst", 1'b0, 4'hF, 16'h0050, 1'b0, 4'b0010, 1'b0);
        step("mid_after", 1'b1, 4'hF, 16'h0050, 1'b0, 4'h0, 1'b0);
        step("mid_first", 1'b1, 4'h0, 16'h0050, 1'b0, 4'b0001, 1'b0);
        step("mid_idle", 1'b1, 4'h0, 16'h0050, 1'b0, 4'h0, 1'b0);

        @(negedge clk);
        #3;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
